gem_frame_builder: RTL and testbench



---
 rtl/gem_frame_builder_if.sv | 21 ++
 rtl/gem_frame_builder.sv | 130 +++++++++++++
 tb/tb_gem_frame_builder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gem_frame_builder_if.sv
// Link-side bundle of the GEM frame builder: per-BX cluster input and MGT TX output.
// master = cluster mux / test source, slave = frame builder.
interface gem_frame_builder_if;
    logic        bx_strobe;
    logic [55:0] gem_data;
    logic        overflow;
    logic        bc0;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;
    logic        ltncy_trig;

    modport master (
        output bx_strobe, gem_data, overflow, bc0,
        input  tx_data, tx_charisk, ltncy_trig
    );

    modport slave (
        input  bx_strobe, gem_data, overflow, bc0,
        output tx_data, tx_charisk, ltncy_trig
    );
endinterface

// File: rtl/gem_frame_builder.sv
// Packs one 56-bit cluster word per BX into two 32-bit 8b/10b TX words at 80 MHz,
// with K-character control, PRBS-7 test pattern, error injection and strobe-phase tracking.
module gem_frame_builder #(
    parameter int         MARKER_PERIOD_LOG2 = 7,
    parameter logic [6:0] PRBS_SEED          = 7'h7F
) (
    input  logic                 clk_80,
    input  logic                 reset_n,
    gem_frame_builder_if.slave   link,
    input  logic                 ena_test_pat,
    input  logic                 inj_err,
    output logic                 frame_locked,
    output logic [7:0]           missed_strobe_cnt
);

    typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [MARKER_PERIOD_LOG2-1:0] CNT_ONE = {{(MARKER_PERIOD_LOG2-1){1'b0}}, 1'b1};

    state_t                        state, next_state;
    logic                          capture, phase_err;
    logic [MARKER_PERIOD_LOG2-1:0] frame_cnt, cnt_used;
    logic                          marker_hit, marker_r;
    logic [55:0]                   payload_new, payload_r;
    logic [7:0]                    ctrl_new, ctrl_r;
    logic [6:0]                    prbs;
    logic                          err_pending;

    always_ff @(posedge clk_80) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // A strobe is legal in IDLE or in the word1 cycle; in word0 or missing in word1 it drops lock.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        phase_err  = 1'b0;
        case (state)
            IDLE: begin
                if (link.bx_strobe) begin
                    next_state = WORD0;
                    capture    = 1'b1;
                end
            end
            WORD0: begin
                if (link.bx_strobe) begin
                    next_state = IDLE;
                    phase_err  = 1'b1;
                end else begin
                    next_state = WORD1;
                end
            end
            WORD1: begin
                if (link.bx_strobe) begin
                    next_state = WORD0;
                    capture    = 1'b1;
                end else begin
                    next_state = IDLE;
                    phase_err  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        link.tx_data    = {24'h000000, K28_5};
        link.tx_charisk = 4'b0001;
        link.ltncy_trig = 1'b0;
        frame_locked    = 1'b0;
        case (state)
            WORD0: begin
                link.tx_data    = {payload_r[23:0], ctrl_r};
                link.tx_charisk = 4'b0001;
                link.ltncy_trig = marker_r;
                frame_locked    = 1'b1;
            end
            WORD1: begin
                link.tx_data    = payload_r[55:24];
                link.tx_charisk = 4'b0000;
                frame_locked    = 1'b1;
            end
            default: ;
        endcase
    end

    // The locking frame always counts as frame 0, whatever frame_cnt held before.
    always_comb begin
        cnt_used    = (state == IDLE) ? '0 : frame_cnt;
        marker_hit  = &cnt_used;
        payload_new = ena_test_pat ? {8{prbs}} : link.gem_data;
        payload_new[0] = payload_new[0] ^ (err_pending | inj_err);
        if (link.bc0)         ctrl_new = K28_1;
        else if (marker_hit)  ctrl_new = K28_7;
        else if (link.overflow) ctrl_new = K28_6;
        else                  ctrl_new = K28_5;
    end

    always_ff @(posedge clk_80) begin
        if (!reset_n) begin
            frame_cnt         <= '0;
            prbs              <= PRBS_SEED;
            err_pending       <= 1'b0;
            missed_strobe_cnt <= 8'd0;
            payload_r         <= 56'd0;
            ctrl_r            <= K28_5;
            marker_r          <= 1'b0;
        end else begin
            if (capture) begin
                payload_r   <= payload_new;
                ctrl_r      <= ctrl_new;
                marker_r    <= marker_hit;
                frame_cnt   <= cnt_used + CNT_ONE;
                err_pending <= 1'b0;
                if (ena_test_pat)
                    prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
            end else if (inj_err) begin
                err_pending <= 1'b1;
            end
            if (phase_err && (missed_strobe_cnt != 8'hFF))
                missed_strobe_cnt <= missed_strobe_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_gem_frame_builder.sv
// Directed self-checking bench for gem_frame_builder with hand-computed TX words.
module tb_gem_frame_builder;

    localparam logic [55:0] DATA = 56'h00112233445566;

    logic       clk_80 = 1'b0;
    logic       reset_n = 1'b0;
    logic       ena_test_pat = 1'b0;
    logic       inj_err = 1'b0;
    logic       frame_locked;
    logic [7:0] missed_strobe_cnt;
    int         total = 0;
    int         bad = 0;

    gem_frame_builder_if gif ();

    gem_frame_builder dut (
        .clk_80            (clk_80),
        .reset_n           (reset_n),
        .link              (gif.slave),
        .ena_test_pat      (ena_test_pat),
        .inj_err           (inj_err),
        .frame_locked      (frame_locked),
        .missed_strobe_cnt (missed_strobe_cnt)
    );

    always #5 clk_80 = ~clk_80;

    task automatic step();
        @(posedge clk_80);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic strobe, input logic [55:0] d, input logic ovf,
                                 input logic b0, input logic tp, input logic err);
        gif.bx_strobe = strobe;
        gif.gem_data  = d;
        gif.overflow  = ovf;
        gif.bc0       = b0;
        ena_test_pat  = tp;
        inj_err       = err;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 56'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("rst_data", gif.tx_data, 32'h000000BC);
        checkOutput("rst_charisk", {28'd0, gif.tx_charisk}, 32'h1);
        checkOutput("rst_ltncy", {31'd0, gif.ltncy_trig}, 32'h0);
        checkOutput("rst_locked", {31'd0, frame_locked}, 32'h0);
        checkOutput("rst_missed", {24'd0, missed_strobe_cnt}, 32'h0);
        reset_n = 1'b1;
    endtask

    // Strobe in the current cycle, then check word0 and word1; returns in the word1 cycle.
    task automatic run_frame(input string tag, input logic [55:0] d, input logic ovf, input logic b0,
                             input logic tp, input logic err, input logic [31:0] w0,
                             input logic [31:0] w1, input logic lt);
        applyStimulus(1'b1, d, ovf, b0, tp, err);
        step();
        applyStimulus(1'b0, d, 1'b0, 1'b0, tp, 1'b0);
        checkOutput({tag, "_w0"}, gif.tx_data, w0);
        checkOutput({tag, "_k0"}, {28'd0, gif.tx_charisk}, 32'h1);
        checkOutput({tag, "_lt0"}, {31'd0, gif.ltncy_trig}, {31'd0, lt});
        checkOutput({tag, "_lock"}, {31'd0, frame_locked}, 32'h1);
        step();
        checkOutput({tag, "_w1"}, gif.tx_data, w1);
        checkOutput({tag, "_k1"}, {28'd0, gif.tx_charisk}, 32'h0);
        checkOutput({tag, "_lt1"}, {31'd0, gif.ltncy_trig}, 32'h0);
    endtask

    initial begin
        applyStimulus(1'b0, 56'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic framing and control-character priority
        do_reset();
        run_frame("plain", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);
        run_frame("bc0ovf", DATA, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4455663C, 32'h00112233, 1'b0);
        run_frame("ovf", DATA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h445566DC, 32'h00112233, 1'b0);
        run_frame("after_ovf", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);

        // Latency marker on the 128th frame from lock, then wrap
        do_reset();
        for (int i = 0; i < 130; i++) begin
            run_frame($sformatf("mk%0d", i), DATA, 1'b0, 1'b0, 1'b0, 1'b0,
                      (i == 127) ? 32'h445566FC : 32'h445566BC, 32'h00112233, i == 127);
        end

        // Dropped strobe in the word1 cycle
        step();
        checkOutput("drop_data", gif.tx_data, 32'h000000BC);
        checkOutput("drop_charisk", {28'd0, gif.tx_charisk}, 32'h1);
        checkOutput("drop_locked", {31'd0, frame_locked}, 32'h0);
        checkOutput("drop_missed", {24'd0, missed_strobe_cnt}, 32'h1);
        run_frame("relock", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);
        checkOutput("relock_missed", {24'd0, missed_strobe_cnt}, 32'h1);

        // Saturation: a held strobe gives one odd-phase error every two cycles
        do_reset();
        applyStimulus(1'b1, DATA, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            step();
            step();
            if (k == 1 || k == 254 || k == 255 || k == 300)
                checkOutput($sformatf("sat%0d", k), {24'd0, missed_strobe_cnt},
                            (k > 255) ? 32'd255 : k);
        end
        applyStimulus(1'b0, DATA, 1'b0, 1'b0, 1'b0, 1'b0);

        // Odd-phase strobe suppresses word1 and is not used to relock
        do_reset();
        applyStimulus(1'b1, DATA, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("odd_w0", gif.tx_data, 32'h445566BC);
        step();
        applyStimulus(1'b0, DATA, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("odd_w1_idle", gif.tx_data, 32'h000000BC);
        checkOutput("odd_charisk", {28'd0, gif.tx_charisk}, 32'h1);
        checkOutput("odd_missed", {24'd0, missed_strobe_cnt}, 32'h1);
        checkOutput("odd_locked", {31'd0, frame_locked}, 32'h0);
        step();
        checkOutput("odd_no_relock", {31'd0, frame_locked}, 32'h0);
        run_frame("odd_relock", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);

        // Reset asserted during a word0 cycle
        applyStimulus(1'b1, DATA, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, DATA, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_w0", gif.tx_data, 32'h445566BC);
        reset_n = 1'b0;
        step();
        checkOutput("mid_data", gif.tx_data, 32'h000000BC);
        checkOutput("mid_locked", {31'd0, frame_locked}, 32'h0);
        checkOutput("mid_missed", {24'd0, missed_strobe_cnt}, 32'h0);
        checkOutput("mid_ltncy", {31'd0, gif.ltncy_trig}, 32'h0);
        reset_n = 1'b1;

        // PRBS-7 test pattern: 7F, 7E, (gem frame does not advance), 7C
        do_reset();
        run_frame("prbs0", DATA, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFBC, 32'hFFFFFFFF, 1'b0);
        run_frame("prbs1", DATA, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDFBF7EBC, 32'hFDFBF7EF, 1'b0);
        run_frame("prbs_off", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);
        run_frame("prbs2", DATA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h9F3E7CBC, 32'hF9F3E7CF, 1'b0);

        // Error injection: two pulses before capture give one flip; same-cycle pulse also flips
        do_reset();
        inj_err = 1'b1;
        step();
        inj_err = 1'b0;
        step();
        inj_err = 1'b1;
        step();
        inj_err = 1'b0;
        run_frame("inj_a", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445567BC, 32'h00112233, 1'b0);
        run_frame("inj_a_clr", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);
        run_frame("inj_same", DATA, 1'b0, 1'b0, 1'b0, 1'b1, 32'h445567BC, 32'h00112233, 1'b0);
        run_frame("inj_same_clr", DATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h445566BC, 32'h00112233, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
